// File: rtl/wb_decompressor_if.sv
// Compressed-wishbone link and wishbone bus interfaces used by wb_decompressor.
interface cw_if #(parameter int RW = 16);
  logic [RW-1:0] cw_io_i;   // words from compressor
  logic [RW-1:0] cw_io_o;   // read data back to compressor
  logic          cw_req;
  logic          cw_dir;
  logic          cw_ack;
  logic          cw_err;

  modport master (output cw_io_i, cw_req, cw_dir, input  cw_io_o, cw_ack, cw_err);
  modport slave  (input  cw_io_i, cw_req, cw_dir, output cw_io_o, cw_ack, cw_err);
endinterface

interface wb_bus_if #(parameter int RW = 16, parameter int ADR_W = 24);
  logic             wb_cyc;
  logic             wb_stb;
  logic [ADR_W-1:0] wb_adr;
  logic [RW-1:0]    wb_o_dat;
  logic [RW-1:0]    wb_i_dat;
  logic             wb_we;
  logic [1:0]       wb_sel;
  logic             wb_ack;
  logic             wb_err;

  modport master (output wb_cyc, wb_stb, wb_adr, wb_o_dat, wb_we, wb_sel,
                  input  wb_i_dat, wb_ack, wb_err);
  modport slave  (input  wb_cyc, wb_stb, wb_adr, wb_o_dat, wb_we, wb_sel,
                  output wb_i_dat, wb_ack, wb_err);
endinterface

// File: rtl/wb_decompressor.sv
// Far end of the compressed-wishbone link: rebuilds a wishbone master cycle
// (single beat or 4/8-beat read burst) from cw request words and returns
// data/ack/err over cw. Outputs are decoded from the state register so an
// async reset clears them immediately.
module wb_decompressor #(
  parameter int RW      = 16,
  parameter int ADR_W   = 24,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  cw_if.slave         cw,
  wb_bus_if.master    wb
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_WDAT, S_BUS, S_RESP, S_REL} state_t;

  state_t           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [RW-1:0]    wdat_q, wdat_d;
  logic [RW-1:0]    rdat_q, rdat_d;
  logic [1:0]       sel_q, sel_d;
  logic             we_q, we_d;
  logic [3:0]       beats_q, beats_d;
  logic [7:0]       to_q, to_d;
  logic             err_q, err_d;   // response type of the beat just finished
  logic             drop_q, drop_d; // cw_req fell during the current beat
  logic             last;

  // Transaction ends after an error, the final beat, or once the requester lets go.
  assign last = err_q | (beats_q == 4'd1) | drop_q | ~cw.cw_req;

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      beats_q <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      beats_q <= beats_d;
      to_q    <= to_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    beats_d = beats_q;
    to_d    = to_q;
    err_d   = err_q;
    drop_d  = drop_q;
    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (cw.cw_req) begin
          adr_d[RW-1:0] = cw.cw_io_i;
          state_d       = S_HDR;
        end
      end
      S_HDR: begin
        if (!cw.cw_req) state_d = S_IDLE;
        else begin
          adr_d[ADR_W-1:RW] = cw.cw_io_i[RW-1 -: (ADR_W-RW)];
          sel_d   = cw.cw_io_i[2:1];
          we_d    = cw.cw_dir;
          // bursts are read-only; b8 overrides b4
          beats_d = cw.cw_dir     ? 4'd1 :
                    cw.cw_io_i[4] ? 4'd8 :
                    cw.cw_io_i[3] ? 4'd4 : 4'd1;
          to_d    = '0;
          state_d = cw.cw_dir ? S_WDAT : S_BUS;
        end
      end
      S_WDAT: begin
        if (!cw.cw_req) state_d = S_IDLE;
        else begin
          wdat_d  = cw.cw_io_i;
          to_d    = '0;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (!cw.cw_req) drop_d = 1'b1;
        if (wb.wb_err) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (wb.wb_ack) begin
          err_d   = 1'b0;
          if (!we_q) rdat_d = wb.wb_i_dat;
          state_d = S_RESP;
        end else if (to_q == 8'(TIMEOUT - 1)) begin
          // this is the TIMEOUT-th silent BUS cycle
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      S_RESP: begin
        if (last) state_d = S_REL;
        else begin
          adr_d   = adr_q + 1'b1;
          beats_d = beats_q - 4'd1;
          to_d    = '0;
          state_d = S_BUS;
        end
      end
      S_REL: begin
        if (!cw.cw_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wb.wb_cyc   = (state_q == S_BUS) | ((state_q == S_RESP) & ~last);
  assign wb.wb_stb   = (state_q == S_BUS);
  assign wb.wb_adr   = adr_q;
  assign wb.wb_o_dat = wdat_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_sel   = sel_q;
  assign cw.cw_ack   = (state_q == S_RESP) & ~err_q;
  assign cw.cw_err   = (state_q == S_RESP) &  err_q;
  assign cw.cw_io_o  = rdat_q;

endmodule

// File: tb/tb_wb_decompressor.sv
// Directed bench for wb_decompressor: read, write, bursts, timeout,
// wishbone error, early abort and mid-transaction reset.
module tb_wb_decompressor;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   failed = 0;

  cw_if     #(.RW(16))              cw ();
  wb_bus_if #(.RW(16), .ADR_W(24))  wb ();

  wb_decompressor #(.RW(16), .ADR_W(24), .TIMEOUT(255)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .cw    (cw),
    .wb    (wb)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive W0/W1 (and W2 for writes); returns 1 ns into the first BUS cycle.
  task automatic start(input logic dir, input logic [15:0] w0, input logic [15:0] w1,
                       input logic [15:0] w2);
    cw.cw_req = 1'b1; cw.cw_dir = dir; cw.cw_io_i = w0;
    step();
    cw.cw_io_i = w1;
    step();
    if (dir) begin
      cw.cw_io_i = w2;
      step();
    end
    #1;
  endtask

  // Zero-wait slave for a bounded number of cycles; counts cw strobes.
  task automatic run_burst(output int acks, output int errs);
    acks = 0; errs = 0;
    for (int c = 0; c < 60; c++) begin
      wb.wb_ack   = wb.wb_stb;
      wb.wb_i_dat = 16'(16'h0700 + c);
      step();
      wb.wb_ack = 1'b0;
      #1;
      if (cw.cw_ack) acks++;
      if (cw.cw_err) errs++;
    end
  endtask

  task automatic finish_req();
    cw.cw_req = 1'b0;
    step();
    step();
  endtask

  initial begin
    int a, e, n;
    cw.cw_req = 1'b0; cw.cw_dir = 1'b0; cw.cw_io_i = '0;
    wb.wb_ack = 1'b0; wb.wb_err = 1'b0; wb.wb_i_dat = '0;

    // reset state
    repeat (2) @(posedge i_clk);
    #2;
    chk("rst_cyc", 32'(wb.wb_cyc), 32'd0);
    chk("rst_stb", 32'(wb.wb_stb), 32'd0);
    chk("rst_adr", 32'(wb.wb_adr), 32'd0);
    chk("rst_ack", 32'(cw.cw_ack), 32'd0);
    chk("rst_io_o", 32'(cw.cw_io_o), 32'd0);
    i_rst = 1'b0;
    step();

    // 1: single read, two wait states
    start(1'b0, 16'h1234, 16'h0500, 16'h0000);
    chk("r_cyc", 32'(wb.wb_cyc), 32'd1);
    chk("r_stb", 32'(wb.wb_stb), 32'd1);
    chk("r_adr", 32'(wb.wb_adr), 32'h051234);
    chk("r_we", 32'(wb.wb_we), 32'd0);
    step(); step(); #1;
    chk("r_wait_ack", 32'(cw.cw_ack), 32'd0);
    wb.wb_ack = 1'b1; wb.wb_i_dat = 16'hBEEF;
    step();
    wb.wb_ack = 1'b0; #1;
    chk("r_ack", 32'(cw.cw_ack), 32'd1);
    chk("r_data", 32'(cw.cw_io_o), 32'hBEEF);
    chk("r_resp_stb", 32'(wb.wb_stb), 32'd0);
    chk("r_resp_cyc", 32'(wb.wb_cyc), 32'd0);
    step(); step(); #1;
    chk("r_rel_ack", 32'(cw.cw_ack), 32'd0);
    chk("r_rel_cyc", 32'(wb.wb_cyc), 32'd0);
    finish_req();

    // 2: single write
    start(1'b1, 16'h0010, 16'h0006, 16'hA5A5);
    chk("w_cyc", 32'(wb.wb_cyc), 32'd1);
    chk("w_we", 32'(wb.wb_we), 32'd1);
    chk("w_sel", 32'(wb.wb_sel), 32'd3);
    chk("w_dat", 32'(wb.wb_o_dat), 32'hA5A5);
    chk("w_adr", 32'(wb.wb_adr), 32'h000010);
    wb.wb_ack = 1'b1; wb.wb_i_dat = 16'h1111;
    step();
    wb.wb_ack = 1'b0; #1;
    chk("w_ack", 32'(cw.cw_ack), 32'd1);
    chk("w_io_keep", 32'(cw.cw_io_o), 32'hBEEF);
    step(); #1;
    chk("w_single", 32'(cw.cw_ack), 32'd0);
    finish_req();

    // 3: 8-beat read burst across the 16-bit boundary, zero-wait slave
    start(1'b0, 16'hFFFE, 16'h0016, 16'h0000);
    for (int b = 0; b < 8; b++) begin
      chk("b8_adr", 32'(wb.wb_adr), 32'h00FFFE + 32'(b));
      chk("b8_cyc", 32'(wb.wb_cyc), 32'd1);
      wb.wb_ack = 1'b1; wb.wb_i_dat = 16'(16'h0100 + b);
      step();
      wb.wb_ack = 1'b0; #1;
      chk("b8_ack", 32'(cw.cw_ack), 32'd1);
      chk("b8_data", 32'(cw.cw_io_o), 32'h0100 + 32'(b));
      chk("b8_resp_cyc", 32'(wb.wb_cyc), (b != 7) ? 32'd1 : 32'd0);
      step(); #1;
    end
    chk("b8_end_cyc", 32'(wb.wb_cyc), 32'd0);
    chk("b8_end_ack", 32'(cw.cw_ack), 32'd0);
    finish_req();

    // 4: b4+b8 -> 8 beats; write with b4 -> 1 beat
    start(1'b0, 16'h0000, 16'h001E, 16'h0000);
    run_burst(a, e);
    chk("b48_acks", 32'(a), 32'd8);
    chk("b48_errs", 32'(e), 32'd0);
    finish_req();
    start(1'b1, 16'h0020, 16'h000E, 16'h1234);
    run_burst(a, e);
    chk("wb4_acks", 32'(a), 32'd1);
    chk("wb4_dat", 32'(wb.wb_o_dat), 32'h1234);
    finish_req();

    // 5a: silent slave -> timeout error
    start(1'b0, 16'h0100, 16'h0000, 16'h0000);
    n = 0;
    for (int c = 0; c < 400; c++) begin
      if (cw.cw_err) break;
      if (wb.wb_stb) n++;
      step(); #1;
    end
    chk("to_err", 32'(cw.cw_err), 32'd1);
    chk("to_cycles", 32'(n), 32'd255);
    chk("to_cyc", 32'(wb.wb_cyc), 32'd0);
    step(); #1;
    chk("to_no_more", 32'(wb.wb_stb | cw.cw_ack | cw.cw_err), 32'd0);
    finish_req();

    // 5b: wb_err (with simultaneous ack) on beat 2 of a 4-burst
    start(1'b0, 16'h0200, 16'h000E, 16'h0000);
    wb.wb_ack = 1'b1; wb.wb_i_dat = 16'h2222;
    step();
    wb.wb_ack = 1'b0; #1;
    chk("e_b1_ack", 32'(cw.cw_ack), 32'd1);
    chk("e_b1_cyc", 32'(wb.wb_cyc), 32'd1);
    step(); #1;
    chk("e_b2_adr", 32'(wb.wb_adr), 32'h000201);
    wb.wb_ack = 1'b1; wb.wb_err = 1'b1; wb.wb_i_dat = 16'h3333;
    step();
    wb.wb_ack = 1'b0; wb.wb_err = 1'b0; #1;
    chk("e_err", 32'(cw.cw_err), 32'd1);
    chk("e_no_ack", 32'(cw.cw_ack), 32'd0);
    chk("e_cyc", 32'(wb.wb_cyc), 32'd0);
    chk("e_io_keep", 32'(cw.cw_io_o), 32'h2222);
    step(); #1;
    chk("e_rel_stb", 32'(wb.wb_stb), 32'd0);
    finish_req();

    // 6a: cw_req drops in HDR -> no cycle
    cw.cw_req = 1'b1; cw.cw_dir = 1'b0; cw.cw_io_i = 16'h0300;
    step();
    cw.cw_req = 1'b0;
    step(); #1;
    chk("ab_cyc0", 32'(wb.wb_cyc), 32'd0);
    step(); #1;
    chk("ab_cyc1", 32'(wb.wb_cyc), 32'd0);

    // 6b: reset during BUS, then a clean read
    start(1'b0, 16'h0400, 16'h0000, 16'h0000);
    chk("rb_cyc", 32'(wb.wb_cyc), 32'd1);
    #1 i_rst = 1'b1;
    #1;
    chk("rb_cyc0", 32'(wb.wb_cyc), 32'd0);
    chk("rb_stb0", 32'(wb.wb_stb), 32'd0);
    chk("rb_adr0", 32'(wb.wb_adr), 32'd0);
    chk("rb_io0", 32'(cw.cw_io_o), 32'd0);
    cw.cw_req = 1'b0;
    step();
    i_rst = 1'b0;
    step();
    start(1'b0, 16'h0ABC, 16'h0000, 16'h0000);
    chk("rc_adr", 32'(wb.wb_adr), 32'h000ABC);
    wb.wb_ack = 1'b1; wb.wb_i_dat = 16'h5A5A;
    step();
    wb.wb_ack = 1'b0; #1;
    chk("rc_ack", 32'(cw.cw_ack), 32'd1);
    chk("rc_data", 32'(cw.cw_io_o), 32'h5A5A);
    finish_req();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
